// File: rtl/hada.sv
// hada: shared types for the hada runtime arithmetic blocks.
// Contents:
//   div_op_t : selects truncating (quotRem) or flooring (divMod) division.
package hada;

    typedef enum logic {
        DIV_QUOT_REM = 1'b0,
        DIV_DIV_MOD  = 1'b1
    } div_op_t;

endpackage

// File: rtl/hada_div_step.sv
// hada_div_step: one combinational restoring-division step.
// Ports:
//   i_rem  : partial remainder before the step (WIDTH+1 bits, always < i_div)
//   i_bit  : next dividend bit, MSB first
//   i_div  : divisor magnitude
//   o_rem  : partial remainder after the step
//   o_qbit : quotient bit produced by this step
module hada_div_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    // One extra bit on top so the borrow of the trial subtraction is visible.
    logic [WIDTH+1:0] w_diff;

    always_comb begin
        w_diff = {i_rem, i_bit} - {2'b00, i_div};
        o_qbit = ~w_diff[WIDTH+1];
        o_rem  = o_qbit ? w_diff[WIDTH:0] : {i_rem[WIDTH-1:0], i_bit};
    end

endmodule

// File: rtl/hada_divmod.sv
// hada_divmod: multi-cycle quotRem / divMod divider with valid/ready handshakes.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake; in_a dividend, in_b divisor, in_op operation
//   out_valid/out_ready : result handshake; out_q quotient, out_r remainder/modulus
//   out_divz            : divisor was zero (q=0, r=a)
//   out_ovf             : signed minBound / -1 wrapped
module hada_divmod
    import hada::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  div_op_t          in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_divz,
    output logic             out_ovf
);

    localparam int unsigned      CntW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

    state_t           r_state, w_state_d;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dq;     // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] r_bmag, r_a, r_b;
    div_op_t          r_op;
    logic             r_sa, r_sb;
    logic [WIDTH-1:0] r_q, r_r;
    logic             r_divz, r_ovf, r_valid;

    logic [WIDTH:0]   w_step_rem;
    logic             w_qbit;
    logic             w_in_sa, w_in_sb, w_neg_q, w_floor, w_divz, w_ovf;
    logic [WIDTH-1:0] w_q_sgn, w_r_sgn, w_q_fix, w_r_fix;

    hada_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dq[WIDTH-1]),
        .i_div  (r_bmag),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    assign w_in_sa   = SIGNED && in_a[WIDTH-1];
    assign w_in_sb   = SIGNED && in_b[WIDTH-1];
    assign in_ready  = (r_state == StIdle);
    assign out_valid = r_valid;
    assign out_q     = r_q;
    assign out_r     = r_r;
    assign out_divz  = r_divz;
    assign out_ovf   = r_ovf;

    // Sign fix-up applied to the unsigned magnitudes in the FIX state.
    always_comb begin
        w_divz  = (r_b == '0);
        w_neg_q = r_sa ^ r_sb;
        w_q_sgn = w_neg_q ? -r_dq : r_dq;
        w_r_sgn = r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        w_floor = (r_op == DIV_DIV_MOD) && w_neg_q && (w_r_sgn != '0);
        w_q_fix = w_floor ? (w_q_sgn - WIDTH'(1)) : w_q_sgn;
        w_r_fix = w_floor ? (w_r_sgn + r_b) : w_r_sgn;
        w_ovf   = SIGNED && (r_a == MinVal) && (r_b == '1);
        if (w_divz) begin
            w_q_fix = '0;
            w_r_fix = r_a;
            w_ovf   = 1'b0;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (in_valid) w_state_d = (in_b == '0) ? StFix : StCalc;
            StCalc: if (r_cnt == '0) w_state_d = StFix;
            StFix:  w_state_d = StDone;
            StDone: if (r_valid && out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dq    <= '0;
            r_bmag  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= DIV_QUOT_REM;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_divz  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            // out_valid is registered one cycle behind DONE entry and drops on handshake.
            r_valid <= (r_state == StDone) && !(r_valid && out_ready);
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_op   <= in_op;
                        r_sa   <= w_in_sa;
                        r_sb   <= w_in_sb;
                        r_dq   <= w_in_sa ? -in_a : in_a;
                        r_bmag <= w_in_sb ? -in_b : in_b;
                        r_rem  <= '0;
                        r_cnt  <= CntW'(WIDTH - 1);
                    end
                end
                StCalc: begin
                    r_rem <= w_step_rem;
                    r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CntW'(1);
                end
                StFix: begin
                    r_q    <= w_q_fix;
                    r_r    <= w_r_fix;
                    r_divz <= w_divz;
                    r_ovf  <= w_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hada_divmod.sv
module tb_hada_divmod;
    import hada::*;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed 8-bit instance.
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_divz, s_out_ovf;
    logic [7:0] s_in_a, s_in_b, s_out_q, s_out_r;
    div_op_t    s_in_op;

    // Unsigned 8-bit and 64-bit instances share one request stream.
    logic        u_in_valid, u_out_ready, u8_in_ready, u64_in_ready;
    logic [63:0] u_in_a, u_in_b;
    div_op_t     u_in_op;
    logic        u8_out_valid, u8_out_divz, u8_out_ovf;
    logic [7:0]  u8_out_q, u8_out_r;
    logic        u64_out_valid, u64_out_divz, u64_out_ovf;
    logic [63:0] u64_out_q, u64_out_r;

    int n_vec;
    int n_err;

    // Captured results of the last unsigned transaction.
    logic [7:0]  c8_q, c8_r;
    logic        c8_dz, c8_ov;
    int          c8_lat;
    logic [63:0] c64_q, c64_r;
    logic        c64_dz, c64_ov;
    int          c64_lat;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        div_op_t    op;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } vec_t;

    hada_divmod #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_q(s_out_q), .out_r(s_out_r), .out_divz(s_out_divz), .out_ovf(s_out_ovf)
    );

    hada_divmod #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u_in_valid), .in_ready(u8_in_ready),
        .in_a(u_in_a[7:0]), .in_b(u_in_b[7:0]), .in_op(u_in_op),
        .out_valid(u8_out_valid), .out_ready(u_out_ready),
        .out_q(u8_out_q), .out_r(u8_out_r), .out_divz(u8_out_divz), .out_ovf(u8_out_ovf)
    );

    hada_divmod #(.WIDTH(64), .SIGNED(1'b0)) u_dut_u64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u_in_valid), .in_ready(u64_in_ready),
        .in_a(u_in_a), .in_b(u_in_b), .in_op(u_in_op),
        .out_valid(u64_out_valid), .out_ready(u_out_ready),
        .out_q(u64_out_q), .out_r(u64_out_r), .out_divz(u64_out_divz), .out_ovf(u64_out_ovf)
    );

    // Haskell Int8 quotRem / divMod from plain integer arithmetic.
    function automatic void model_s8(input logic [7:0] a, input logic [7:0] b, input div_op_t op,
                                     output logic [7:0] q, output logic [7:0] r,
                                     output logic dz, output logic ov);
        int ia, ib, iq, ir;
        ia = int'($signed(a));
        ib = int'($signed(b));
        dz = (ib == 0);
        ov = (ia == -128) && (ib == -1);
        if (dz) begin
            q = 8'd0;
            r = a;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            if (op == DIV_DIV_MOD && ir != 0 && ((ir < 0) != (ib < 0))) begin
                iq = iq - 1;
                ir = ir + ib;
            end
            q = iq[7:0];
            r = ir[7:0];
        end
    endfunction

    function automatic void model_u(input longint unsigned a, input longint unsigned b,
                                    output longint unsigned q, output longint unsigned r,
                                    output logic dz);
        dz = (b == 0);
        q  = dz ? 64'd0 : a / b;
        r  = dz ? a : a % b;
    endfunction

    // One request/response on the signed instance; lat = -1 on timeout.
    task automatic s_xact(input logic [7:0] a, input logic [7:0] b, input div_op_t op,
                          input bit pre_ready, output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic ov, output int lat);
        int cyc;
        q = 8'd0; r = 8'd0; dz = 1'b0; ov = 1'b0; lat = -1;
        cyc = 0;
        while (!s_in_ready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        if (!s_in_ready) return;
        s_in_a = a; s_in_b = b; s_in_op = op; s_in_valid = 1'b1; s_out_ready = pre_ready;
        @(posedge clk); #1;
        // Scramble the inputs after the accepting edge; they must be ignored.
        s_in_valid = 1'b0;
        s_in_a = 8'($urandom);
        s_in_b = 8'($urandom);
        s_in_op = ($urandom & 1) ? DIV_DIV_MOD : DIV_QUOT_REM;
        cyc = 0;
        while (!s_out_valid && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        if (!s_out_valid) return;
        lat = cyc; q = s_out_q; r = s_out_r; dz = s_out_divz; ov = s_out_ovf;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic u_xact(input logic [63:0] a, input logic [63:0] b, input div_op_t op);
        int cyc;
        c8_lat = -1; c64_lat = -1;
        cyc = 0;
        while (!(u8_in_ready && u64_in_ready) && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        if (!(u8_in_ready && u64_in_ready)) return;
        u_in_a = a; u_in_b = b; u_in_op = op; u_in_valid = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        u_in_a = {$urandom, $urandom};
        u_in_b = {$urandom, $urandom};
        cyc = 0;
        while ((c8_lat < 0 || c64_lat < 0) && cyc < 200) begin
            if (c8_lat < 0 && u8_out_valid) begin
                c8_lat = cyc; c8_q = u8_out_q; c8_r = u8_out_r;
                c8_dz = u8_out_divz; c8_ov = u8_out_ovf;
            end
            if (c64_lat < 0 && u64_out_valid) begin
                c64_lat = cyc; c64_q = u64_out_q; c64_r = u64_out_r;
                c64_dz = u64_out_divz; c64_ov = u64_out_ovf;
            end
            if (c8_lat < 0 || c64_lat < 0) begin
                @(posedge clk); #1; cyc++;
            end
        end
        u_out_ready = 1'b1;
        @(posedge clk); #1;
        u_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_q !== 8'd0 ||
            s_out_r !== 8'd0 || s_out_divz !== 1'b0 || s_out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_s8: rdy=%b vld=%b q=%h r=%h dz=%b ov=%b, want 1 0 00 00 0 0",
                     s_in_ready, s_out_valid, s_out_q, s_out_r, s_out_divz, s_out_ovf);
        end
        n_vec++;
        if (u8_in_ready !== 1'b1 || u8_out_valid !== 1'b0 || u8_out_q !== 8'd0 ||
            u64_in_ready !== 1'b1 || u64_out_valid !== 1'b0 || u64_out_r !== 64'd0) begin
            n_err++;
            $display("FAIL reset_u: rdy8=%b vld8=%b q8=%h rdy64=%b vld64=%b r64=%h, want 1 0 0 1 0 0",
                     u8_in_ready, u8_out_valid, u8_out_q, u64_in_ready, u64_out_valid,
                     u64_out_r);
        end
    endtask

    task automatic test_spec_vectors();
        vec_t       tbl [6];
        logic [7:0] q, r;
        logic       dz, ov;
        int         lat;
        tbl[0] = '{8'hF9, 8'h02, DIV_QUOT_REM, 8'hFD, 8'hFF, 1'b0, 1'b0, 10};
        tbl[1] = '{8'hF9, 8'h02, DIV_DIV_MOD,  8'hFC, 8'h01, 1'b0, 1'b0, 10};
        tbl[2] = '{8'h07, 8'hFE, DIV_DIV_MOD,  8'hFC, 8'hFF, 1'b0, 1'b0, 10};
        tbl[3] = '{8'h06, 8'hFE, DIV_DIV_MOD,  8'hFD, 8'h00, 1'b0, 1'b0, 10};
        tbl[4] = '{8'h05, 8'h00, DIV_QUOT_REM, 8'h00, 8'h05, 1'b1, 1'b0, 2};
        tbl[5] = '{8'h80, 8'hFF, DIV_QUOT_REM, 8'h80, 8'h00, 1'b0, 1'b1, 10};
        foreach (tbl[i]) begin
            s_xact(tbl[i].a, tbl[i].b, tbl[i].op, 1'b0, q, r, dz, ov, lat);
            n_vec++;
            if (q !== tbl[i].q || r !== tbl[i].r || dz !== tbl[i].dz || ov !== tbl[i].ov ||
                lat != tbl[i].lat) begin
                n_err++;
                $display("FAIL spec_vec%0d: q=%h r=%h dz=%b ov=%b lat=%0d, want %h %h %b %b %0d",
                         i, q, r, dz, ov, lat, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov,
                         tbl[i].lat);
            end
        end
    endtask

    task automatic test_random_signed();
        logic [7:0] a, b, q, r, eq, er;
        logic       dz, ov, edz, eov;
        div_op_t    op;
        int         lat;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 8'h00;
                1:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            op = ($urandom & 1) ? DIV_DIV_MOD : DIV_QUOT_REM;
            model_s8(a, b, op, eq, er, edz, eov);
            s_xact(a, b, op, 1'($urandom), q, r, dz, ov, lat);
            n_vec++;
            if (q !== eq || r !== er || dz !== edz || ov !== eov || lat != (edz ? 2 : 10)) begin
                n_err++;
                $display("FAIL rand_s8 a=%h b=%h op=%0d: q=%h r=%h dz=%b ov=%b lat=%0d, want %h %h %b %b %0d",
                         a, b, op, q, r, dz, ov, lat, eq, er, edz, eov, edz ? 2 : 10);
            end
        end
    endtask

    task automatic test_unsigned();
        logic [63:0] a, b;
        longint unsigned q8, r8, q64, r64;
        logic dz8, dz64;
        div_op_t op;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0:  begin a = 64'd200; b = 64'd7; op = DIV_QUOT_REM; end
                1:  begin a = 64'd200; b = 64'd7; op = DIV_DIV_MOD;  end
                2:  begin a = '1;      b = 64'd3; op = DIV_DIV_MOD;  end
                3:  begin a = 64'd5;   b = 64'd0; op = DIV_QUOT_REM; end
                default: begin
                    a  = {$urandom, $urandom};
                    b  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(1, 300))
                                                     : {$urandom, $urandom};
                    op = ($urandom & 1) ? DIV_DIV_MOD : DIV_QUOT_REM;
                end
            endcase
            model_u({56'd0, a[7:0]}, {56'd0, b[7:0]}, q8, r8, dz8);
            model_u(a, b, q64, r64, dz64);
            u_xact(a, b, op);
            n_vec++;
            if (c8_q !== q8[7:0] || c8_r !== r8[7:0] || c8_dz !== dz8 || c8_ov !== 1'b0 ||
                c8_lat != (dz8 ? 2 : 10)) begin
                n_err++;
                $display("FAIL rand_u8 a=%h b=%h: q=%h r=%h dz=%b ov=%b lat=%0d, want %h %h %b 0 %0d",
                         a[7:0], b[7:0], c8_q, c8_r, c8_dz, c8_ov, c8_lat, q8[7:0], r8[7:0],
                         dz8, dz8 ? 2 : 10);
            end
            n_vec++;
            if (c64_q !== q64 || c64_r !== r64 || c64_dz !== dz64 || c64_ov !== 1'b0 ||
                c64_lat != (dz64 ? 2 : 66)) begin
                n_err++;
                $display("FAIL rand_u64 a=%h b=%h: q=%h r=%h dz=%b ov=%b lat=%0d, want %h %h %b 0 %0d",
                         a, b, c64_q, c64_r, c64_dz, c64_ov, c64_lat, q64, r64, dz64,
                         dz64 ? 2 : 66);
            end
            if (i < 3) begin
                n_vec++;
                if (i < 2 && (c8_q !== 8'd28 || c8_r !== 8'd4)) begin
                    n_err++;
                    $display("FAIL u8_200_7 op=%0d: q=%0d r=%0d, want 28 4", op, c8_q, c8_r);
                end else if (i == 2 && (c64_q !== 64'h5555_5555_5555_5555 || c64_r !== 64'd0))
                begin
                    n_err++;
                    $display("FAIL u64_max_3: q=%h r=%h, want 5555555555555555 0", c64_q, c64_r);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        s_in_a = 8'hF9; s_in_b = 8'h02; s_in_op = DIV_DIV_MOD; s_in_valid = 1'b1;
        s_out_ready = 1'b0;
        @(posedge clk); #1;
        // Keep a second request pending for the whole busy/backpressure period.
        s_in_a = 8'd100; s_in_b = 8'd7; s_in_op = DIV_QUOT_REM;
        cyc = 0;
        while (!s_out_valid && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_out_q !== 8'hFC ||
                s_out_r !== 8'h01) begin
                n_err++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b q=%h r=%h, want 1 0 fc 01",
                         i, s_out_valid, s_in_ready, s_out_q, s_out_r);
            end
            @(posedge clk); #1;
        end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        n_vec++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: vld=%b rdy=%b, want 0 1", s_out_valid, s_in_ready);
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        n_vec++;
        if (s_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: rdy=%b, want 0", s_in_ready);
        end
        cyc = 0;
        while (!s_out_valid && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        n_vec++;
        if (s_out_q !== 8'd14 || s_out_r !== 8'd2 || cyc != 10) begin
            n_err++;
            $display("FAIL bp_pending: q=%0d r=%0d lat=%0d, want 14 2 10", s_out_q, s_out_r, cyc);
        end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, q, r, eq, er;
        logic       dz, ov, edz, eov;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            model_s8(a, b, DIV_DIV_MOD, eq, er, edz, eov);
            s_xact(a, b, DIV_DIV_MOD, 1'b1, q, r, dz, ov, lat);
            n_vec++;
            if (q !== eq || r !== er || ov !== eov || lat != 10 || s_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b a=%h b=%h: q=%h r=%h ov=%b lat=%0d vld_after=%b, want %h %h %b 10 0",
                         a, b, q, r, ov, lat, s_out_valid, eq, er, eov);
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        logic [7:0] q, r;
        logic       dz, ov;
        int         lat, cyc;
        s_in_a = 8'hF9; s_in_b = 8'h02; s_in_op = DIV_QUOT_REM; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_calc: vld=%b rdy=%b, want 0 1", s_out_valid, s_in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_xact(8'hF9, 8'h02, DIV_QUOT_REM, 1'b0, q, r, dz, ov, lat);
        n_vec++;
        if (q !== 8'hFD || r !== 8'hFF || lat != 10) begin
            n_err++;
            $display("FAIL rst_fresh: q=%h r=%h lat=%0d, want fd ff 10", q, r, lat);
        end
        // Reset while a result is being held in DONE.
        s_in_a = 8'h05; s_in_b = 8'h00; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        cyc = 0;
        while (!s_out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        n_vec++;
        if (s_out_valid !== 1'b1 || s_out_r !== 8'h05 || s_out_divz !== 1'b1) begin
            n_err++;
            $display("FAIL rst_hold: vld=%b r=%h dz=%b, want 1 05 1", s_out_valid, s_out_r,
                     s_out_divz);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_out_q !== 8'd0 ||
            s_out_r !== 8'd0 || s_out_divz !== 1'b0) begin
            n_err++;
            $display("FAIL rst_done: vld=%b rdy=%b q=%h r=%h dz=%b, want 0 1 00 00 0",
                     s_out_valid, s_in_ready, s_out_q, s_out_r, s_out_divz);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        s_in_valid = 1'b0; s_in_a = 8'd0; s_in_b = 8'd0; s_in_op = DIV_QUOT_REM;
        s_out_ready = 1'b0;
        u_in_valid = 1'b0; u_in_a = 64'd0; u_in_b = 64'd0; u_in_op = DIV_QUOT_REM;
        u_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_spec_vectors();
        test_random_signed();
        test_unsigned();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_flight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
